// File: rtl/v_pkg.sv
// Shared vector-unit definitions: LSU opcodes, load-sequencer state encoding and helpers.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 10
`endif

package v_pkg;

  localparam logic [3:0] VLSU_NOP    = 4'h0;
  localparam logic [3:0] VLSU_VLE8   = 4'h1;
  localparam logic [3:0] VLSU_VLE16  = 4'h2;
  localparam logic [3:0] VLSU_VLE32  = 4'h3;
  localparam logic [3:0] VLSU_VLSE8  = 4'h4;
  localparam logic [3:0] VLSU_VLSE16 = 4'h5;
  localparam logic [3:0] VLSU_VLSE32 = 4'h6;
  localparam logic [3:0] VLSU_VSE8   = 4'h8;
  localparam logic [3:0] VLSU_VSE16  = 4'h9;
  localparam logic [3:0] VLSU_VSE32  = 4'hA;

  localparam int VREG_GROUP_W = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } v_ldseq_state_t;

  // Reserved LMUL encodings fall back to a single register.
  function automatic logic [2:0] lmul_to_nbeats(input logic [2:0] lmul);
    case (lmul)
      3'b000:  return 3'd1;
      3'b001:  return 3'd2;
      3'b010:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic is_unit_stride_load(input logic [3:0] op);
    return (op == VLSU_VLE8) || (op == VLSU_VLE16) || (op == VLSU_VLE32);
  endfunction

endpackage

// File: rtl/v_ld_collect.sv
// Beat collector: registers the grant-to-data delay and packs returned beats into a register-group image.
module v_ld_collect
  import v_pkg::*;
#(
  parameter int BEAT_W  = 128,
  parameter int GROUP_W = VREG_GROUP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               cap_en,
  input  logic [1:0]         cap_beat,
  input  logic [BEAT_W-1:0]  beat_data,
  output logic [GROUP_W-1:0] buf_q,
  output logic [GROUP_W-1:0] buf_nxt
);

  logic       rvalid;
  logic [1:0] rbeat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rbeat  <= 2'd0;
    end else begin
      rvalid <= cap_en;
      rbeat  <= cap_beat;
    end
  end

  // buf_nxt is exposed so the final beat can be forwarded on the same edge it lands.
  always_comb begin
    buf_nxt = buf_q;
    if (clr) begin
      buf_nxt = '0;
    end else if (rvalid) begin
      buf_nxt[int'(rbeat)*BEAT_W +: BEAT_W] = beat_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_nxt;
    end
  end

endmodule

// File: rtl/v_load_seq.sv
// Vector unit-stride load sequencer: issues 1/2/4 bank-parallel beats under grant control
// and hands an assembled 512-bit register-group image to writeback.
module v_load_seq
  import v_pkg::*;
#(
  parameter int DATAMEM_BITS = `DATAMEM_BITS,
  parameter int BEAT_W       = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_op,
  input  logic [2:0]              req_lmul,
  input  logic [31:0]             req_addr,
  input  logic [4:0]              req_vd,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic [DATAMEM_BITS-1:0] data_addr0,
  output logic [DATAMEM_BITS-1:0] data_addr1,
  output logic [DATAMEM_BITS-1:0] data_addr2,
  output logic [DATAMEM_BITS-1:0] data_addr3,
  input  logic [31:0]             l_data_in0,
  input  logic [31:0]             l_data_in1,
  input  logic [31:0]             l_data_in2,
  input  logic [31:0]             l_data_in3,
  output logic [4*BEAT_W-1:0]     l_data_out,
  output logic                    wb_valid,
  output logic [4:0]              wb_vd,
  output logic [2:0]              wb_nregs,
  output logic                    wb_err
);

  localparam int GROUP_W = 4 * BEAT_W;

  v_ldseq_state_t          state;
  logic [DATAMEM_BITS-1:0] base_q;
  logic [DATAMEM_BITS-1:0] cur_addr;
  logic [2:0]              nbeats_q;
  logic [1:0]              issue_cnt;
  logic [4:0]              vd_q;
  logic                    accept;
  logic                    issue_gnt;
  logic                    last_beat;
  logic [GROUP_W-1:0]      buf_q;
  logic [GROUP_W-1:0]      buf_nxt;
  logic                    unused_addr;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;
  assign issue_gnt = (state == ISSUE) && mem_gnt;
  assign last_beat = ({1'b0, issue_cnt} == (nbeats_q - 3'd1));

  // Bank word addresses wrap modulo the bank depth.
  assign cur_addr   = base_q + DATAMEM_BITS'(issue_cnt);
  assign mem_req    = (state == ISSUE);
  assign data_addr0 = cur_addr;
  assign data_addr1 = cur_addr;
  assign data_addr2 = cur_addr;
  assign data_addr3 = cur_addr;

  assign unused_addr = ^{req_addr, 1'b0};

  v_ld_collect #(
    .BEAT_W  (BEAT_W),
    .GROUP_W (GROUP_W)
  ) u_collect (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .cap_en    (issue_gnt),
    .cap_beat  (issue_cnt),
    .beat_data ({l_data_in3, l_data_in2, l_data_in1, l_data_in0}),
    .buf_q     (buf_q),
    .buf_nxt   (buf_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      nbeats_q   <= 3'd0;
      issue_cnt  <= 2'd0;
      vd_q       <= 5'd0;
      wb_valid   <= 1'b0;
      wb_vd      <= 5'd0;
      wb_nregs   <= 3'd0;
      wb_err     <= 1'b0;
      l_data_out <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            base_q    <= req_addr[DATAMEM_BITS-1:0];
            vd_q      <= req_vd;
            nbeats_q  <= lmul_to_nbeats(req_lmul);
            issue_cnt <= 2'd0;
            if (is_unit_stride_load(req_op)) begin
              state <= ISSUE;
            end else begin
              // Unsupported ops retire immediately without touching the banks.
              state      <= DONE;
              wb_valid   <= 1'b1;
              wb_err     <= 1'b1;
              wb_vd      <= req_vd;
              wb_nregs   <= lmul_to_nbeats(req_lmul);
              l_data_out <= buf_nxt;
            end
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            issue_cnt <= issue_cnt + 2'd1;
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          state      <= DONE;
          wb_valid   <= 1'b1;
          wb_err     <= 1'b0;
          wb_vd      <= vd_q;
          wb_nregs   <= nbeats_q;
          l_data_out <= buf_nxt;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [GROUP_W-1:0] unused_buf;
  assign unused_buf = buf_q & '0;

endmodule

// File: tb/tb_v_load_seq.sv
// Self-checking bench for v_load_seq: directed cases plus randomized requests against a transaction-level model.
module tb_v_load_seq;
  import v_pkg::*;

  localparam int AW    = `DATAMEM_BITS;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [2:0]    req_lmul;
  logic [31:0]   req_addr;
  logic [4:0]    req_vd;
  logic          mem_req;
  logic          mem_gnt;
  logic [AW-1:0] data_addr0, data_addr1, data_addr2, data_addr3;
  logic [31:0]   l_data_in0, l_data_in1, l_data_in2, l_data_in3;
  logic [511:0]  l_data_out;
  logic          wb_valid;
  logic [4:0]    wb_vd;
  logic [2:0]    wb_nregs;
  logic          wb_err;

  always #5 clk = ~clk;

  v_load_seq #(.DATAMEM_BITS(AW), .BEAT_W(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_lmul(req_lmul), .req_addr(req_addr), .req_vd(req_vd),
    .mem_req(mem_req), .mem_gnt(mem_gnt),
    .data_addr0(data_addr0), .data_addr1(data_addr1),
    .data_addr2(data_addr2), .data_addr3(data_addr3),
    .l_data_in0(l_data_in0), .l_data_in1(l_data_in1),
    .l_data_in2(l_data_in2), .l_data_in3(l_data_in3),
    .l_data_out(l_data_out), .wb_valid(wb_valid), .wb_vd(wb_vd),
    .wb_nregs(wb_nregs), .wb_err(wb_err)
  );

  logic [127:0] mem [DEPTH];
  logic         gnt_seq [128];
  int           ncomp = 0;
  int           nfail = 0;
  logic         prev_g;
  logic [AW-1:0] prev_a;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bank model: returns the word at the previously granted address, junk otherwise.
  task automatic drive_bank();
    logic [127:0] w;
    if (prev_g) w = mem[int'(prev_a)];
    else        w = {$urandom, $urandom, $urandom, $urandom};
    {l_data_in3, l_data_in2, l_data_in1, l_data_in0} = w;
  endtask

  task automatic gnt_all();
    for (int i = 0; i < 128; i++) gnt_seq[i] = 1'b1;
  endtask

  task automatic gnt_rand();
    for (int i = 0; i < 128; i++) gnt_seq[i] = (i >= 20) ? 1'b1 : ($urandom_range(0, 9) < 7);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},   512'(req_ready),  512'(1));
    chk({tag, "_memreq"},  512'(mem_req),    512'(0));
    chk({tag, "_addr"},    512'(data_addr0), 512'(0));
    chk({tag, "_data"},    l_data_out,       512'(0));
    chk({tag, "_wbvalid"}, 512'(wb_valid),   512'(0));
    chk({tag, "_wbvd"},    512'(wb_vd),      512'(0));
    chk({tag, "_nregs"},   512'(wb_nregs),   512'(0));
    chk({tag, "_err"},     512'(wb_err),     512'(0));
  endtask

  // One request from acceptance (cycle 0) through the IDLE cycle after writeback.
  task automatic run_req(input logic [3:0] op, input logic [2:0] lmul, input logic [31:0] addr,
                         input logic [4:0] vd, input logic hold);
    int           n, grants, issue_end, done;
    logic         sup;
    logic [511:0] img;
    logic [AW-1:0] a0, exp_a;
    logic         exp_req;

    sup = (op == VLSU_VLE8) || (op == VLSU_VLE16) || (op == VLSU_VLE32);
    n   = (lmul == 3'd0) ? 1 : (lmul == 3'd1) ? 2 : (lmul == 3'd2) ? 4 : 1;
    a0  = addr[AW-1:0];
    img = '0;
    if (sup)
      for (int b = 0; b < n; b++) img[128*b +: 128] = mem[(int'(a0) + b) % DEPTH];

    grants = 0;
    issue_end = 0;
    if (sup)
      for (int k = 1; k < 100 && grants < n; k++)
        if (gnt_seq[k]) begin
          grants++;
          if (grants == n) issue_end = k;
        end
    done = sup ? issue_end + 2 : 1;

    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_lmul = lmul; req_addr = addr; req_vd = vd;
    mem_gnt = 1'($urandom);
    prev_g = 1'b0;
    drive_bank();
    @(negedge clk);
    chk("ready_c0", 512'(req_ready), 512'(1));

    grants = 0;
    for (int k = 1; k <= done + 1; k++) begin
      @(posedge clk); #1;
      req_valid = hold && (k <= done);
      if (hold) begin
        req_op = 4'($urandom); req_lmul = 3'($urandom); req_addr = $urandom; req_vd = 5'($urandom);
      end
      mem_gnt = gnt_seq[k];
      drive_bank();
      @(negedge clk);
      exp_req = sup && (k <= issue_end);
      chk($sformatf("memreq_c%0d", k), 512'(mem_req), 512'(exp_req));
      if (exp_req) begin
        exp_a = AW'((int'(a0) + grants) % DEPTH);
        chk($sformatf("addr0_c%0d", k), 512'(data_addr0), 512'(exp_a));
        chk($sformatf("addr1_c%0d", k), 512'(data_addr1), 512'(exp_a));
        chk($sformatf("addr2_c%0d", k), 512'(data_addr2), 512'(exp_a));
        chk($sformatf("addr3_c%0d", k), 512'(data_addr3), 512'(exp_a));
      end
      chk($sformatf("wbvalid_c%0d", k), 512'(wb_valid), 512'(k == done));
      if (k == done || k == done + 1) begin
        chk($sformatf("data_c%0d", k),  l_data_out,      img);
        chk($sformatf("wbvd_c%0d", k),  512'(wb_vd),     512'(vd));
        chk($sformatf("nregs_c%0d", k), 512'(wb_nregs),  512'(n));
        chk($sformatf("err_c%0d", k),   512'(wb_err),    512'(!sup));
      end
      if (k == done + 1) chk("ready_after", 512'(req_ready), 512'(1));
      prev_g = mem_req && mem_gnt;
      prev_a = data_addr0;
      if (exp_req && mem_gnt) grants++;
    end
  endtask

  initial begin
    logic [3:0] ops [7];
    ops[0] = VLSU_VLE8;   ops[1] = VLSU_VLE16; ops[2] = VLSU_VLE32; ops[3] = VLSU_VLE32;
    ops[4] = VLSU_VLSE32; ops[5] = VLSU_VSE8;  ops[6] = 4'hF;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_lmul = '0; req_addr = '0; req_vd = '0;
    mem_gnt = 1'b0; prev_g = 1'b0; prev_a = '0;
    {l_data_in3, l_data_in2, l_data_in1, l_data_in0} = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[16'h10] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

    #12;
    chk_reset_vals("rst_hold");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_rel");

    gnt_all();
    run_req(VLSU_VLE32, 3'b000, 32'h10, 5'd1, 1'b0);
    run_req(VLSU_VLE8,  3'b010, 32'h20, 5'd2, 1'b0);

    gnt_all();
    gnt_seq[1] = 1'b0; gnt_seq[2] = 1'b0; gnt_seq[4] = 1'b0;
    run_req(VLSU_VLE16, 3'b001, 32'h30, 5'd3, 1'b1);

    gnt_all();
    run_req(VLSU_VLE32, 3'b001, 32'(DEPTH - 1), 5'd4, 1'b0);
    run_req(VLSU_VLE32, 3'b011, 32'h44, 5'd5, 1'b0);
    run_req(VLSU_VLSE32, 3'b001, 32'h50, 5'd6, 1'b0);

    // Abort a 4-beat load mid-flight with an asynchronous reset.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = VLSU_VLE8; req_lmul = 3'b010; req_addr = 32'h60; req_vd = 5'd7;
    prev_g = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'b1;
      drive_bank();
      prev_g = 1'b1; prev_a = AW'(32'h60 + k - 1);
    end
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(posedge clk); #1 rst = 1'b0; prev_g = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort_wbvalid_%0d", k), 512'(wb_valid), 512'(0));
      chk($sformatf("abort_memreq_%0d", k),  512'(mem_req),  512'(0));
    end
    run_req(VLSU_VLE32, 3'b000, 32'h70, 5'd8, 1'b0);

    for (int r = 0; r < 16; r++) begin
      logic [31:0] a;
      gnt_rand();
      a = (r % 4 == 0) ? 32'(DEPTH - 1 - $urandom_range(0, 2)) : $urandom;
      run_req(ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)), a, 5'($urandom), 1'($urandom));
    end

    @(posedge clk); #1 req_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/v_load_seq.md
# v_load_seq

Sequencer for vector unit-stride loads between the vector issue stage and the four 32-bit data-memory banks. It accepts one load request with a valid/ready handshake. It then issues 1, 2 or 4 bank-parallel 128-bit beats, stalling whenever the shared-bank grant is withheld. It assembles the returned beats into a 512-bit register-group image and presents that image to vector register writeback with a one-cycle valid pulse.

## Interface
Parameters:
- DATAMEM_BITS, `DATAMEM_BITS: width of each bank word address.
- BEAT_W, 128: bits per beat (4 banks x 32).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- req_valid  in  1  load request present
- req_ready  out  1  sequencer can accept a request (IDLE only)
- req_op  in  4  v_lsu_op encoding (VLSU_* from v_pkg)
- req_lmul  in  3  LMUL field
- req_addr  in  32  base bank word address
- req_vd  in  5  destination vector register
- mem_req  out  1  requesting the four banks this cycle
- mem_gnt  in  1  banks granted this cycle (core has priority upstream)
- data_addr0..data_addr3  out  DATAMEM_BITS  bank addresses, all equal
- l_data_in0..l_data_in3  in  32  bank read data, valid 1 cycle after a granted address
- l_data_out  out  512  assembled register-group data
- wb_valid  out  1  one-cycle writeback pulse
- wb_vd  out  5  latched req_vd
- wb_nregs  out  3  registers written: 1, 2 or 4
- wb_err  out  1  unsupported op; qualifies wb_valid

## Operation
- States: IDLE, ISSUE, DRAIN, DONE (typedef v_ldseq_state_t).
- IDLE: req_ready=1. On req_valid, latch op, addr, vd and nbeats; clear the buffer; clear issue_cnt.
  - nbeats: lmul 000→1, 001→2, 010→4, any other value→1.
  - Supported op (VLSU_VLE8/16/32) → ISSUE. Any other op → DONE with err=1 and no memory access.
- ISSUE: mem_req=1. data_addrN = (base + issue_cnt) truncated to DATAMEM_BITS; modulo wrap allowed.
  - With mem_gnt=1: issue_cnt++, and rvalid/rbeat are registered for the next cycle.
  - With mem_gnt=0: address and counter hold.
  - Granted issue of beat nbeats-1 → DRAIN.
- Capture: when registered rvalid=1, buffer[128*rbeat +: 128] = {l_data_in3, l_data_in2, l_data_in1, l_data_in0}. Capture is independent of state.
- DRAIN: mem_req=0. Waits one cycle so the last beat is captured → DONE.
- DONE:
  - wb_valid=1, wb_err=err.
  - l_data_out = buffer; bits above 128*nbeats are zero.
  - wb_vd and wb_nregs are valid.
  - Next state → IDLE.
- l_data_out, wb_vd, wb_nregs and wb_err hold their values until the next DONE.
- Element width (VLE8/16/32) does not change beat count or packing. The register image is raw bytes.

## Timing
- Reset values:
  - state=IDLE, req_ready=1 (combinational from state).
  - mem_req=0, data_addrN=0.
  - l_data_out=0, wb_valid=0, wb_vd=0, wb_nregs=0, wb_err=0.
  - buffer=0, rvalid=0.
- Zero-stall latency, request accepted in cycle 0:
  - ISSUE occupies cycles 1..N.
  - DRAIN is cycle N+1.
  - wb_valid is high in cycle N+2.
  - Resulting latencies: 3, 4 and 6 cycles for N=1, 2, 4.
- Each cycle of mem_gnt=0 during ISSUE adds exactly one cycle.
- Error request: wb_valid with wb_err=1 in cycle 1.
- req_valid outside IDLE is ignored. Back-to-back requests: next accept is in the IDLE cycle after DONE.
- mem_gnt outside ISSUE is ignored.
- rst mid-operation: immediate return to reset values. No wb_valid for the aborted request; an in-flight beat is discarded.

## Structure
- v_pkg:
  - add v_ldseq_state_t;
  - add function lmul_to_nbeats(lmul) returning 3 bits;
  - VLSU_* opcodes already reside there.
- Sub-module v_ld_collect:
  - 512-bit beat buffer with clear, capture-enable and 2-bit beat index;
  - registered rvalid/rbeat;
  - zero on reset.
- Top level contains the FSM, counters and address generation.

## Test plan
- VLE32, lmul=000, addr=0x10, mem_gnt=1, bank data {D,C,B,A} → data_addr=0x10 in cycle 1. wb_valid in cycle 3. l_data_out[127:0]={D,C,B,A}, upper bits 0, wb_nregs=1.
- VLE8, lmul=010, addr=0x20 → addresses 0x20..0x23 in cycles 1–4. wb_valid in cycle 6 with four beats packed in order, wb_nregs=4.
- VLE16, lmul=001, mem_gnt low in cycles 1–2 and cycle 4 → addresses hold during stalls. wb_valid in cycle 7 with correct 256-bit image.
- Address wrap: addr = 2^DATAMEM_BITS-1, lmul=001 → second address is 0.
  - Reserved lmul=011 → one beat, wb_nregs=1.
- VLSU_VLSE32 request → mem_req stays 0. wb_valid and wb_err=1 in cycle 1, then req_ready=1 in cycle 2.
- rst asserted in cycle 3 of a 4-beat load → all outputs at reset values at once. No wb_valid. A following VLE32 completes normally with a clean buffer.
